// File: rtl/arith_pkg.sv
// Shared arithmetic definitions: operation encodings and the chunk-width helper
// used to split a WIDTH-bit carry chain into equal pipeline chunks.
package arith_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  function automatic int chunk_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/fa_chunk.sv
// Combinational CW-bit ripple-carry adder made of full-adder cells. Also exposes
// the carry into the chunk MSB so the top chunk can derive signed overflow.
module fa_chunk #(
  parameter int CW = 4
) (
  input  logic [CW-1:0] a,
  input  logic [CW-1:0] b,
  input  logic          cin,
  output logic [CW-1:0] sum,
  output logic          cout,
  output logic          cmsb
);

  logic carry;

  // Each loop iteration is one full-adder cell; carry ripples LSB to MSB.
  always_comb begin
    carry = cin;
    cmsb  = cin;
    sum   = '0;
    for (int i = 0; i < CW; i++) begin
      if (i == CW - 1) cmsb = carry;
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: the carry chain is cut into STAGES
// registered chunks, with a single global advance enable for backpressure.
module pipelined_addsub
  import arith_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = chunk_width(WIDTH, STAGES);

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
  end

  logic             en;
  logic [WIDTH-1:0] b_eff;
  logic             c0;

  assign en       = !out_valid || out_ready;
  assign in_ready = en || rst;
  assign b_eff    = (sub == OP_SUB) ? ~b : b;
  assign c0       = (sub == OP_SUB) ? 1'b1 : cin;

  // Stage k adds chunk k; its register keeps finished low sum bits and the
  // still-unused high operand bits, shifted down so the next chunk sits at bit 0.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CW;
    localparam int HI = (k + 1) * CW;
    localparam int RW = WIDTH - LO;

    logic [RW-1:0] a_src;
    logic [RW-1:0] b_src;
    logic          c_in;
    logic          v_in;
    logic [CW-1:0] ch_sum;
    logic          ch_cout;
    logic [HI-1:0] sum_d;

    logic          v_q;
    logic          c_q;
    logic [HI-1:0] sum_q;

    if (k == 0) begin : g_src
      assign a_src = a;
      assign b_src = b_eff;
      assign c_in  = c0;
      assign v_in  = in_valid;
      assign sum_d = ch_sum;
    end else begin : g_src
      assign a_src = g_stage[k-1].g_rem.a_q;
      assign b_src = g_stage[k-1].g_rem.b_q;
      assign c_in  = g_stage[k-1].c_q;
      assign v_in  = g_stage[k-1].v_q;
      assign sum_d = {ch_sum, g_stage[k-1].sum_q};
    end

    if (k == STAGES - 1) begin : g_last
      logic ch_cmsb;
      logic ovf_q;

      fa_chunk #(.CW(CW)) u_chunk (
        .a    (a_src[CW-1:0]),
        .b    (b_src[CW-1:0]),
        .cin  (c_in),
        .sum  (ch_sum),
        .cout (ch_cout),
        .cmsb (ch_cmsb)
      );

      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= ch_cmsb ^ ch_cout;
        end
      end
    end else begin : g_mid
      logic unused_cmsb;

      fa_chunk #(.CW(CW)) u_chunk (
        .a    (a_src[CW-1:0]),
        .b    (b_src[CW-1:0]),
        .cin  (c_in),
        .sum  (ch_sum),
        .cout (ch_cout),
        .cmsb (unused_cmsb)
      );
    end

    if (k < STAGES - 1) begin : g_rem
      logic [RW-CW-1:0] a_q;
      logic [RW-CW-1:0] b_q;

      always_ff @(posedge clk) begin
        if (en) begin
          a_q <= a_src[RW-1:CW];
          b_q <= b_src[RW-1:CW];
        end
      end
    end

    // Everything holds when the output is stalled, bubbles included.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        sum_q <= '0;
      end else if (en) begin
        v_q   <= v_in;
        c_q   <= ch_cout;
        sum_q <= sum_d;
      end
    end
  end

  assign out_valid = g_stage[STAGES-1].v_q;
  assign sum       = g_stage[STAGES-1].sum_q;
  assign cout      = g_stage[STAGES-1].c_q;
  assign ovf       = g_stage[STAGES-1].g_last.ovf_q;

endmodule
